// File: rtl/udma_filter_rx_datawrite_if.sv
// Write-side bundle for the filter RX datawrite block: the L2 write request
// channel and the incoming filter stream. The master view is the datawrite
// block; the slave view is whatever sits on the other side (L2 arbiter/stream).
interface udma_filter_rx_datawrite_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int L2_AWIDTH_NOAL = 15
);
    logic                      rx_ch_req_o;
    logic [L2_AWIDTH_NOAL-1:0] rx_ch_addr_o;
    logic [1:0]                rx_ch_datasize_o;
    logic [DATA_WIDTH-1:0]     rx_ch_data_o;
    logic                      rx_ch_gnt_i;

    logic [DATA_WIDTH-1:0]     stream_data_i;
    logic [1:0]                stream_datasize_i;
    logic                      stream_valid_i;
    logic                      stream_sof_i;
    logic                      stream_eof_i;
    logic                      stream_ready_o;

    modport master (
        output rx_ch_req_o, rx_ch_addr_o, rx_ch_datasize_o, rx_ch_data_o,
        input  rx_ch_gnt_i,
        input  stream_data_i, stream_datasize_i, stream_valid_i, stream_sof_i, stream_eof_i,
        output stream_ready_o
    );

    modport slave (
        input  rx_ch_req_o, rx_ch_addr_o, rx_ch_datasize_o, rx_ch_data_o,
        output rx_ch_gnt_i,
        output stream_data_i, stream_datasize_i, stream_valid_i, stream_sof_i, stream_eof_i,
        input  stream_ready_o
    );
endinterface

// File: rtl/udma_filter_rx_datawrite.sv
// Filter RX datawrite: moves stream beats into L2 through a single-entry beat
// buffer, generating linear or 2D addresses and flagging eof markers that do
// not line up with the configured transfer shape.
//
// state      | meaning
// ST_IDLE    | waiting for cmd_start_i, stream back-pressured
// ST_RUNNING | accepting beats and issuing L2 writes until the final grant
module udma_filter_rx_datawrite #(
    parameter int DATA_WIDTH     = 32,
    parameter int L2_AWIDTH_NOAL = 15,
    parameter int TRANS_SIZE     = 16
) (
    input  logic                        clk_i,
    input  logic                        resetn_i,
    udma_filter_rx_datawrite_if.master  bus,
    input  logic                        cmd_start_i,
    output logic                        cmd_done_o,
    output logic                        err_o,
    input  logic [L2_AWIDTH_NOAL-1:0]   cfg_start_addr_i,
    input  logic [1:0]                  cfg_datasize_i,
    input  logic                        cfg_mode_i,
    input  logic [TRANS_SIZE-1:0]       cfg_len0_i,
    input  logic [TRANS_SIZE-1:0]       cfg_len1_i,
    input  logic [TRANS_SIZE-1:0]       cfg_len2_i
);

    typedef enum logic {ST_IDLE, ST_RUNNING} state_t;

    state_t                    state_q, state_d;
    logic                      valid_q, valid_d;
    logic                      eof_q, eof_d;
    logic [DATA_WIDTH-1:0]     data_q, data_d;
    logic                      mode_q, mode_d;
    logic [1:0]                dsize_q, dsize_d;
    logic [L2_AWIDTH_NOAL-1:0] ptr_q, ptr_d;
    logic [L2_AWIDTH_NOAL-1:0] row_q, row_d;
    logic [TRANS_SIZE-1:0]     cnt_w_q, cnt_w_d;
    logic [TRANS_SIZE-1:0]     cnt_l_q, cnt_l_d;
    logic                      err_q, err_d;

    logic [L2_AWIDTH_NOAL-1:0] incr;
    logic [L2_AWIDTH_NOAL-1:0] len2_aw;
    logic                      row_end;
    logic                      last;
    logic                      grant;
    logic                      ready;
    logic                      accept;
    logic                      eof_bad;
    logic                      unused_stream;

    // sof and the stream size code carry no addressing information here
    assign unused_stream = ^{bus.stream_datasize_i, bus.stream_sof_i};

    assign len2_aw = L2_AWIDTH_NOAL'(cfg_len2_i);
    assign row_end = (cnt_w_q == cfg_len0_i);
    assign last    = row_end & (~mode_q | (cnt_l_q == cfg_len1_i));
    assign grant   = valid_q & bus.rx_ch_gnt_i;
    // the final beat's grant must not pull in a beat belonging to the next command
    assign ready   = (state_q == ST_RUNNING) & (~valid_q | (bus.rx_ch_gnt_i & ~last));
    assign accept  = bus.stream_valid_i & ready;
    // in 2D an eof closing any row is legal; a missing eof on the final beat never is
    assign eof_bad = mode_q ? (eof_q ? ~row_end : last) : (eof_q ^ last);

    assign bus.rx_ch_req_o      = valid_q;
    assign bus.rx_ch_addr_o     = ptr_q;
    assign bus.rx_ch_datasize_o = dsize_q;
    assign bus.rx_ch_data_o     = data_q;
    assign bus.stream_ready_o   = ready;
    assign cmd_done_o           = grant & last;
    assign err_o                = err_q;

    // byte step per beat; size code 3 deliberately parks on one address
    always_comb begin
        incr = '0;
        case (dsize_q)
            2'd0:    incr = L2_AWIDTH_NOAL'(1);
            2'd1:    incr = L2_AWIDTH_NOAL'(2);
            2'd2:    incr = L2_AWIDTH_NOAL'(4);
            default: incr = '0;
        endcase
    end

    // next-state, address walk and beat buffer update
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        eof_d   = eof_q;
        data_d  = data_q;
        mode_d  = mode_q;
        dsize_d = dsize_q;
        ptr_d   = ptr_q;
        row_d   = row_q;
        cnt_w_d = cnt_w_q;
        cnt_l_d = cnt_l_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_start_i) begin
                    state_d = ST_RUNNING;
                    mode_d  = cfg_mode_i;
                    dsize_d = cfg_datasize_i;
                    ptr_d   = cfg_start_addr_i;
                    row_d   = cfg_start_addr_i;
                    cnt_w_d = '0;
                    cnt_l_d = '0;
                    err_d   = 1'b0;
                end
            end
            ST_RUNNING: begin
                if (grant) begin
                    if (eof_bad) begin
                        err_d = 1'b1;
                    end
                    if (last) begin
                        state_d = ST_IDLE;
                    end else if (mode_q && row_end) begin
                        cnt_w_d = '0;
                        cnt_l_d = cnt_l_q + 1'b1;
                        row_d   = row_q + len2_aw;
                        ptr_d   = row_q + len2_aw;
                    end else begin
                        cnt_w_d = cnt_w_q + 1'b1;
                        ptr_d   = ptr_q + incr;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            valid_d = 1'b1;
            data_d  = bus.stream_data_i;
            eof_d   = bus.stream_eof_i;
        end else if (grant) begin
            valid_d = 1'b0;
        end
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // datapath registers; reset drops any buffered beat without a grant
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            valid_q <= 1'b0;
            eof_q   <= 1'b0;
            data_q  <= '0;
            mode_q  <= 1'b0;
            dsize_q <= 2'd0;
            ptr_q   <= '0;
            row_q   <= '0;
            cnt_w_q <= '0;
            cnt_l_q <= '0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            eof_q   <= eof_d;
            data_q  <= data_d;
            mode_q  <= mode_d;
            dsize_q <= dsize_d;
            ptr_q   <= ptr_d;
            row_q   <= row_d;
            cnt_w_q <= cnt_w_d;
            cnt_l_q <= cnt_l_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_udma_filter_rx_datawrite.sv
// Bench for udma_filter_rx_datawrite: directed shapes plus randomized
// transfers; expected writes are queued at accept time and checked by a
// monitor at each grant.
`timescale 1ns/1ps
module tb_udma_filter_rx_datawrite;
    localparam int DW = 32;
    localparam int AW = 15;
    localparam int TS = 16;

    logic          clk_i = 1'b0;
    logic          resetn_i;
    logic          cmd_start_i;
    logic          cmd_done_o;
    logic          err_o;
    logic [AW-1:0] cfg_start_addr_i;
    logic [1:0]    cfg_datasize_i;
    logic          cfg_mode_i;
    logic [TS-1:0] cfg_len0_i;
    logic [TS-1:0] cfg_len1_i;
    logic [TS-1:0] cfg_len2_i;

    always #5 clk_i = ~clk_i;

    udma_filter_rx_datawrite_if #(.DATA_WIDTH(DW), .L2_AWIDTH_NOAL(AW)) bus ();

    udma_filter_rx_datawrite #(.DATA_WIDTH(DW), .L2_AWIDTH_NOAL(AW), .TRANS_SIZE(TS)) dut (
        .clk_i            (clk_i),
        .resetn_i         (resetn_i),
        .bus              (bus),
        .cmd_start_i      (cmd_start_i),
        .cmd_done_o       (cmd_done_o),
        .err_o            (err_o),
        .cfg_start_addr_i (cfg_start_addr_i),
        .cfg_datasize_i   (cfg_datasize_i),
        .cfg_mode_i       (cfg_mode_i),
        .cfg_len0_i       (cfg_len0_i),
        .cfg_len1_i       (cfg_len1_i),
        .cfg_len2_i       (cfg_len2_i)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [1:0]    ds;
        bit            fin;
        bit            err_before;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   grants_seen = 0;
    int   done_seen = 0;
    bit   xfer_active = 1'b0;
    int   gnt_pct = 100;
    int   block_at = -1;
    int   block_left = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // grant generator with an optional forced stall on a chosen beat
    always @(posedge clk_i) begin
        #1;
        if (block_left > 0 && grants_seen == block_at && bus.rx_ch_req_o) begin
            bus.rx_ch_gnt_i = 1'b0;
            block_left--;
        end else begin
            bus.rx_ch_gnt_i = (int'($urandom_range(99)) < gnt_pct);
        end
    end

    // monitor: sampled mid-cycle, compares each granted write with the scoreboard
    logic          pend = 1'b0;
    logic [AW-1:0] pend_addr;
    logic [DW-1:0] pend_data;
    always @(negedge clk_i) begin
        if (!resetn_i) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                check("hold_req", bus.rx_ch_req_o, 1);
                check("hold_addr", bus.rx_ch_addr_o, pend_addr);
                check("hold_data", bus.rx_ch_data_o, pend_data);
            end
            if (bus.rx_ch_req_o && !bus.rx_ch_gnt_i)
                check("ready_while_stalled", bus.stream_ready_o, 0);
            if (!xfer_active)
                check("ready_idle", bus.stream_ready_o, 0);
            if (cmd_done_o)
                done_seen++;
            if (bus.rx_ch_req_o && bus.rx_ch_gnt_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write actual addr=0x%0h required=no write", bus.rx_ch_addr_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("wr_addr", bus.rx_ch_addr_o, mon_e.addr);
                    check("wr_data", bus.rx_ch_data_o, mon_e.data);
                    check("wr_datasize", bus.rx_ch_datasize_o, mon_e.ds);
                    check("done_on_grant", cmd_done_o, mon_e.fin);
                    check("err_before_grant", err_o, mon_e.err_before);
                    if (mon_e.fin) begin
                        check("ready_on_final", bus.stream_ready_o, 0);
                        xfer_active = 1'b0;
                    end
                end
                grants_seen++;
            end else begin
                check("done_no_grant", cmd_done_o, 0);
            end
            pend      = bus.rx_ch_req_o & ~bus.rx_ch_gnt_i;
            pend_addr = bus.rx_ch_addr_o;
            pend_data = bus.rx_ch_data_o;
        end
    end

    // eof_mode: -1 well-formed, -2 random, >=0 bitmask of beats carrying eof
    task automatic run_transfer(input bit mode, input logic [1:0] ds, input logic [AW-1:0] start,
                                input int len0, input int len1, input int len2,
                                input int eof_mode, input int valid_pct, input int abort_after);
        int            n, base, done_base, incr, w, l, tmo;
        bit            err_acc, eof, fin, bad;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        incr = (ds == 2'd0) ? 1 : (ds == 2'd1) ? 2 : (ds == 2'd2) ? 4 : 0;
        n    = mode ? (len0 + 1) * (len1 + 1) : len0 + 1;
        cfg_mode_i       = mode;
        cfg_datasize_i   = ds;
        cfg_start_addr_i = start;
        cfg_len0_i       = TS'(len0);
        cfg_len1_i       = TS'(len1);
        cfg_len2_i       = TS'(len2);
        base      = grants_seen;
        done_base = done_seen;
        err_acc   = 1'b0;
        cmd_start_i = 1'b1;
        @(posedge clk_i); #1;
        cmd_start_i = 1'b0;
        xfer_active = 1'b1;
        for (int k = 0; k < n; k++) begin
            w   = k % (len0 + 1);
            l   = mode ? k / (len0 + 1) : 0;
            a   = AW'(int'(start) + l * len2 + w * incr);
            fin = (k == n - 1);
            if (eof_mode == -1)      eof = mode ? (w == len0) : fin;
            else if (eof_mode == -2) eof = ($urandom_range(1) == 1);
            else                     eof = ((eof_mode >> k) & 1) == 1;
            bad = mode ? (eof ? (w != len0) : fin) : (eof != fin);
            d   = $urandom;
            tmo = 0;
            forever begin
                bus.stream_valid_i    = (int'($urandom_range(99)) < valid_pct);
                bus.stream_data_i     = d;
                bus.stream_eof_i      = eof;
                bus.stream_sof_i      = (k == 0);
                bus.stream_datasize_i = 2'($urandom_range(3));
                @(negedge clk_i);
                if (abort_after > 0 && (grants_seen - base) >= abort_after) begin
                    bus.stream_valid_i = 1'b0;
                    return;
                end
                if (bus.stream_valid_i && bus.stream_ready_o) begin
                    exp_q.push_back('{a, d, ds, fin, err_acc});
                    err_acc = err_acc | bad;
                    break;
                end
                tmo++;
                if (tmo > 300) begin
                    checks++;
                    errors++;
                    $display("FAIL accept_timeout beat=%0d actual=not accepted required=accepted", k);
                    bus.stream_valid_i = 1'b0;
                    return;
                end
                @(posedge clk_i); #1;
            end
            @(posedge clk_i); #1;
        end
        // keep a stray beat offered across the final grant; it must not be taken
        bus.stream_valid_i = 1'b1;
        bus.stream_data_i  = 32'hDEAD_BEEF;
        bus.stream_eof_i   = 1'b0;
        tmo = 0;
        while ((grants_seen - base) < n && tmo < 1000) begin
            @(negedge clk_i);
            tmo++;
        end
        if ((grants_seen - base) < n) begin
            checks++;
            errors++;
            $display("FAIL grant_timeout actual=%0d required=%0d grants", grants_seen - base, n);
        end
        @(negedge clk_i);
        check("err_final", err_o, err_acc);
        check("done_count", done_seen - done_base, 1);
        repeat (2) @(negedge clk_i);
        @(posedge clk_i); #1;
        bus.stream_valid_i = 1'b0;
    endtask

    initial begin
        #400000;
        errors++;
        $display("FAIL watchdog actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] st;
        resetn_i              = 1'b0;
        cmd_start_i           = 1'b0;
        cfg_start_addr_i      = '0;
        cfg_datasize_i        = 2'd0;
        cfg_mode_i            = 1'b0;
        cfg_len0_i            = '0;
        cfg_len1_i            = '0;
        cfg_len2_i            = '0;
        bus.stream_valid_i    = 1'b0;
        bus.stream_data_i     = '0;
        bus.stream_eof_i      = 1'b0;
        bus.stream_sof_i      = 1'b0;
        bus.stream_datasize_i = 2'd0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_req", bus.rx_ch_req_o, 0);
        check("rst_ready", bus.stream_ready_o, 0);
        check("rst_done", cmd_done_o, 0);
        check("rst_err", err_o, 0);
        check("rst_addr", bus.rx_ch_addr_o, 0);
        check("rst_datasize", bus.rx_ch_datasize_o, 0);
        @(posedge clk_i); #1;
        resetn_i = 1'b1;
        @(posedge clk_i); #1;

        // linear word, 4 beats from 0x100
        run_transfer(1'b0, 2'd2, 15'h100, 3, 0, 0, -1, 100, 0);
        // 2D byte, 2x3 with row pitch 0x10
        run_transfer(1'b1, 2'd0, 15'h040, 1, 2, 'h10, -1, 100, 0);
        // stall the second beat for 5 cycles
        block_at   = grants_seen + 1;
        block_left = 5;
        run_transfer(1'b0, 2'd2, 15'h180, 3, 0, 0, -1, 100, 0);
        check("stall_applied", block_left, 0);
        // early eof on beat 2 of 3 sets err, next start clears it
        run_transfer(1'b0, 2'd2, 15'h010, 2, 0, 0, 'b110, 100, 0);
        run_transfer(1'b0, 2'd1, 15'h7FFC, 3, 0, 0, -1, 100, 0);
        // size code 3 repeats the start address
        run_transfer(1'b0, 2'd3, 15'h055, 3, 0, 0, -1, 100, 0);

        // reset after 2 of 8 beats, then a fresh start at 0x200
        run_transfer(1'b0, 2'd2, 15'h300, 7, 0, 0, -1, 100, 2);
        #1 resetn_i = 1'b0;
        #1;
        check("rst_mid_req", bus.rx_ch_req_o, 0);
        check("rst_mid_ready", bus.stream_ready_o, 0);
        check("rst_mid_done", cmd_done_o, 0);
        check("rst_mid_err", err_o, 0);
        exp_q.delete();
        xfer_active        = 1'b0;
        bus.stream_valid_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 resetn_i = 1'b1;
        @(posedge clk_i); #1;
        run_transfer(1'b0, 2'd2, 15'h200, 3, 0, 0, -1, 100, 0);

        for (int t = 0; t < 25; t++) begin
            gnt_pct = 30 + int'($urandom_range(70));
            st      = AW'($urandom);
            run_transfer(($urandom_range(1) == 1), 2'($urandom_range(3)), st,
                         int'($urandom_range(5)), int'($urandom_range(3)),
                         int'($urandom_range(32767)),
                         ($urandom_range(3) == 0) ? -2 : -1,
                         40 + int'($urandom_range(60)), 0);
        end
        gnt_pct = 100;

        repeat (5) @(posedge clk_i);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/udma_filter_rx_datawrite.md
UDMA_FILTER_RX_DATAWRITE -- requirements
Module: udma_filter_rx_datawrite

Interface
REQ-001 SHALL have parameters DATA_WIDTH, default 32, stream/L2 data width; L2_AWIDTH_NOAL, default 15, L2 byte address width; TRANS_SIZE, default 16, counter width.
REQ-002 SHALL have ports: clk_i in 1 clock; resetn_i in 1 reset, asynchronous, active-low.
REQ-003 SHALL have ports: rx_ch_req_o out 1 write request; rx_ch_addr_o out L2_AWIDTH_NOAL byte address; rx_ch_datasize_o out 2 size code; rx_ch_data_o out DATA_WIDTH write data; rx_ch_gnt_i in 1 grant.
REQ-004 SHALL have ports: cmd_start_i in 1 start pulse; cmd_done_o out 1 done pulse; err_o out 1 sticky framing error.
REQ-005 SHALL have ports: cfg_start_addr_i in L2_AWIDTH_NOAL; cfg_datasize_i in 2 (0=byte, 1=half, 2=word); cfg_mode_i in 1 (0=linear, 1=2D); cfg_len0_i, cfg_len1_i, cfg_len2_i in TRANS_SIZE each.
REQ-006 SHALL have ports: stream_data_i in DATA_WIDTH; stream_datasize_i in 2 (ignored); stream_valid_i in 1; stream_sof_i in 1; stream_eof_i in 1; stream_ready_o out 1.

Function
REQ-007 SHALL implement FSM ST_IDLE/ST_RUNNING; IDLE->RUNNING on cmd_start_i; RUNNING->IDLE on grant of final beat; cmd_start_i in RUNNING ignored.
REQ-008 On start, SHALL latch cfg_mode_i and cfg_datasize_i, load r_ptr and r_row = cfg_start_addr_i, clear r_cnt_w, r_cnt_l and err_o; other cfg_* SHALL be sampled live.
REQ-009 SHALL hold one output beat register (data, eof flag, valid); rx_ch_req_o = valid; rx_ch_data_o = buffered data; rx_ch_addr_o = r_ptr; rx_ch_datasize_o = latched datasize.
REQ-010 stream_ready_o SHALL = RUNNING & (~valid | (rx_ch_gnt_i & ~last)), where last = granted beat is final; beat accepted when stream_valid_i & stream_ready_o.
REQ-011 Grant and new accept in same cycle SHALL replace buffer with zero bubble; grant without accept clears valid.
REQ-012 Byte increment SHALL be 1/2/4 for datasize 0/1/2 and 0 for 3; address arithmetic SHALL wrap modulo 2^L2_AWIDTH_NOAL.
REQ-013 Linear: on each grant, if r_cnt_w == cfg_len0_i then final beat; else r_cnt_w+1, r_ptr += increment. Transfer = len0+1 beats.
REQ-014 2D: on grant, if r_cnt_w == len0 and r_cnt_l == len1 then final; else if r_cnt_w == len0 then r_cnt_w=0, r_cnt_l+1, r_row += cfg_len2_i, r_ptr = r_row + cfg_len2_i; else r_cnt_w+1, r_ptr += increment. Transfer = (len0+1)*(len1+1) beats.
REQ-015 cmd_done_o SHALL pulse exactly one cycle, the cycle the final beat is granted (combinational from grant).
REQ-016 err_o SHALL set on grant of a beat whose eof flag differs from last (linear: eof on final beat only; 2D: eof on final beat of each row acceptable and SHALL NOT set err); cleared only by start or reset.
REQ-017 stream_sof_i SHALL be ignored for addressing; beats arriving in IDLE SHALL be back-pressured (ready=0), never dropped.
REQ-018 rx_ch_req_o, once asserted, SHALL stay asserted with stable addr/data until granted.
REQ-019 Datasize 3 SHALL write repeatedly to cfg_start_addr_i without error.

Reset
REQ-020 On resetn_i low, asynchronously: state ST_IDLE, valid=0, rx_ch_req_o=0, stream_ready_o=0, cmd_done_o=0, err_o=0, all pointers/counters 0, latched mode 0, datasize 0.
REQ-021 Reset mid-transfer SHALL abandon buffered beat without grant; next start SHALL begin fresh.

Verification
REQ-022 Linear word: start 0x100, len0=3, gnt always 1, 4 beats eof on last -> writes 0x100,0x104,0x108,0x10C; done on 4th grant; err_o=0.
REQ-023 2D byte: start 0x40, len0=1, len1=2, len2=0x10, eof per row end -> addresses 0x40,0x41,0x50,0x51,0x60,0x61; single done.
REQ-024 Backpressure: gnt held 0 for 5 cycles on beat 2 -> req, addr, data stable; stream_ready_o=0; no beat lost; sequence intact.
REQ-025 Linear len0=2, eof on beat 2 of 3 -> err_o=1 after beat 2 grant, stays 1 through done; next start clears it.
REQ-026 Final beat granted while stream_valid_i=1 -> stream_ready_o=0 that cycle; next beat held until new start.
REQ-027 Reset asserted after 2 of 8 beats -> all outputs at reset values; restart at 0x200 writes 0x200 first.
